// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM bus responder.
// Contents: FSM state encoding and the width of the phase down-counter.
package sram_pkg;

    // Phase counter width; covers phase lengths of 1..15 clocks.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sram_responder.sv
// Bus responder that turns each memory-bus request into one timed cycle on
// an external asynchronous 8-bit SRAM (programmable setup/strobe/hold), then
// holds a level acknowledge until the initiator drops cs.
//
// Ports:
//   i_clk, i_reset        clock; asynchronous active-high reset
//   i_addr, i_dat, i_we   bus request payload (sampled only in IDLE)
//   i_cs                  bus request, held high until o_ack is seen
//   o_dat                 last SRAM read value (registered)
//   o_ack                 level acknowledge, high in DONE while i_cs = 1
//   o_sram_addr           SRAM address (registered)
//   o_sram_dq_out         SRAM write data
//   o_sram_dq_oe          DQ pad drive enable (tristate lives in the wrapper)
//   i_sram_dq_in          SRAM read data
//   o_sram_ce_n/oe_n/we_n SRAM chip/output/write enables, active low
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_dat,
    output logic [7:0]            o_dat,
    input  logic                  i_we,
    input  logic                  i_cs,
    output logic                  o_ack,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [7:0]            o_sram_dq_out,
    output logic                  o_sram_dq_oe,
    input  logic [7:0]            i_sram_dq_in,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n
);

    // Counter reload values: a phase of N clocks counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SETUP_LOAD  =
        (SETUP_CYCLES == 0) ? '0 : CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   =
        (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              dq_out_q;
    logic                    dq_oe_q;
    logic                    ce_n_q;
    logic                    oe_n_q;
    logic                    we_n_q;
    logic                    ack_q;
    logic [7:0]              dat_q;

    // Phase sequencer; every SRAM/bus output is a register written here.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_cs) begin
                        addr_q   <= i_addr;
                        we_q     <= i_we;
                        dq_out_q <= i_dat;
                        ce_n_q   <= 1'b0;
                        dq_oe_q  <= i_we;
                        if (SETUP_CYCLES != 0) begin
                            state_q <= ST_SETUP;
                            cnt_q   <= SETUP_LOAD;
                        end else begin
                            // No setup: strobe asserts together with CE.
                            state_q <= ST_STROBE;
                            cnt_q   <= STROBE_LOAD;
                            oe_n_q  <= i_we;
                            we_n_q  <= ~i_we;
                        end
                    end
                end

                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= STROBE_LOAD;
                        oe_n_q  <= we_q;
                        we_n_q  <= ~we_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_STROBE: begin
                    if (cnt_q == '0) begin
                        oe_n_q <= 1'b1;
                        we_n_q <= 1'b1;
                        if (!we_q) begin
                            dat_q <= i_sram_dq_in;
                        end
                        if (HOLD_CYCLES != 0) begin
                            state_q <= ST_HOLD;
                            cnt_q   <= HOLD_LOAD;
                        end else begin
                            // Cycle complete; ack only if still requested.
                            ce_n_q  <= 1'b1;
                            dq_oe_q <= 1'b0;
                            if (i_cs) begin
                                state_q <= ST_DONE;
                                ack_q   <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        ce_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        if (i_cs) begin
                            state_q <= ST_DONE;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    if (!i_cs) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_dat         = dat_q;
    assign o_ack         = ack_q;
    assign o_sram_addr   = addr_q;
    assign o_sram_dq_out = dq_out_q;
    assign o_sram_dq_oe  = dq_oe_q;
    assign o_sram_ce_n   = ce_n_q;
    assign o_sram_oe_n   = oe_n_q;
    assign o_sram_we_n   = we_n_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Bus responder (slave) for the system memory bus (addr/dat/we/cs/ack) driven by the CPU/UART-master mux.
- Converts each bus request into a timed cycle on an external asynchronous 8-bit SRAM, with programmable setup, strobe and hold times.
- Holds a level acknowledge until the initiator drops cs, so the CPU wait logic (wait_n = ack while memcs) works unchanged.

Parameters:
- ADDR_WIDTH, 16, bus and SRAM address width.
- SETUP_CYCLES, 1, clocks with address/CE valid before the strobe (0..15, 0 allowed).
- STROBE_CYCLES, 2, clocks OE_n/WE_n are held low (1..15).
- HOLD_CYCLES, 1, clocks address/data are held after the strobe deasserts (0..15, 0 allowed).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_addr  in  ADDR_WIDTH  bus address.
- i_dat  in  8  bus write data.
- o_dat  out  8  bus read data (registered).
- i_we  in  1  1 = write, 0 = read.
- i_cs  in  1  request; held high until ack is seen.
- o_ack  out  1  level acknowledge.
- o_sram_addr  out  ADDR_WIDTH  SRAM address (registered).
- o_sram_dq_out  out  8  SRAM write data.
- o_sram_dq_oe  out  1  drive enable for the DQ pads.
- i_sram_dq_in  in  8  SRAM read data.
- o_sram_ce_n  out  1  chip enable, active low.
- o_sram_oe_n  out  1  output enable, active low.
- o_sram_we_n  out  1  write enable, active low.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; o_ack = 0; o_dat = 0.
  - ce_n = oe_n = we_n = 1; dq_oe = 0.
  - sram_addr = 0; dq_out = 0.
- All outputs are registered. One 4-bit down-counter times the phases.
- IDLE:
  - If i_cs = 1, capture i_addr, i_we and i_dat into o_sram_addr, a we latch and o_sram_dq_out.
  - Next state is SETUP; if SETUP_CYCLES = 0, go directly to STROBE.
  - Bus inputs are not sampled again until the next IDLE.
- SETUP: ce_n = 0; dq_oe = we latch; lasts SETUP_CYCLES clocks.
- STROBE:
  - ce_n = 0; oe_n = 0 for reads, we_n = 0 for writes; lasts STROBE_CYCLES clocks.
  - Reads: o_dat captures i_sram_dq_in on the clock edge that ends the last STROBE cycle.
- HOLD:
  - ce_n = 0; oe_n = we_n = 1; address and dq_oe unchanged.
  - Lasts HOLD_CYCLES clocks; if 0, go from STROBE directly to DONE/IDLE.
- DONE:
  - ce_n = 1; dq_oe = 0; o_ack = 1 while i_cs = 1.
  - The cycle after i_cs is sampled low: o_ack = 0 and state = IDLE.
- Latency: if i_cs is sampled high at edge N, o_ack is high after edge N+SETUP+STROBE+HOLD (defaults: N+4).
- o_dat:
  - Valid no later than the cycle o_ack first rises.
  - Holds the last read value; writes never change it.
- Back-to-back requests: at least one IDLE cycle between transactions.
  - If the next request arrives as cs stays low only one cycle, it is captured in that IDLE cycle.
- i_cs dropped mid-transaction:
  - The SRAM cycle always completes with full timing; strobes are never truncated.
  - On the end of HOLD (or STROBE if HOLD = 0) with i_cs = 0, go straight to IDLE; o_ack never asserts.
- Changes to i_addr, i_dat or i_we during a transaction are ignored.
- we_n and oe_n are never low in the same cycle. we_n is only low while dq_oe = 1 and the address is stable.
- Reset mid-transaction: strobes and CE deassert asynchronously; any pending ack is lost.

Decomposition:
- Shared package `sram_pkg`: state encoding (IDLE, SETUP, STROBE, HOLD, DONE) and the counter width constant (4).
- No sub-module; the phase counter stays inline.
- The top-level tristate (dq = oe ? dq_out : 'z) lives in the board wrapper, not in this block.

Test Plan:
- Read, defaults: SRAM model holds 0xA5 at 0x1234; cs/we=0 with addr 0x1234 at edge N -> oe_n low for exactly 2 cycles from N+1, o_ack high after N+4, o_dat=0xA5, ack drops one cycle after cs drops.
- Write: addr 0x00FF, dat 0x3C, we=1 -> dq_oe high across SETUP..HOLD, we_n low 2 cycles, oe_n stays 1, model reads back 0x3C, o_dat unchanged.
- Zero setup/hold (SETUP=0, STROBE=1, HOLD=0): read -> strobe starts the edge after cs is sampled, o_ack after N+1.
- Abort: cs dropped 1 cycle into STROBE -> full 2-cycle strobe still issued, o_ack stays 0, back in IDLE after HOLD, next request served normally.
- Input churn: toggle i_addr/i_dat/i_we every cycle after capture -> sram_addr and we/oe behaviour follow the captured values only.
- Async reset asserted during write STROBE -> we_n, ce_n = 1 and dq_oe = 0 before the next clock edge, o_ack = 0, o_dat = 0.
